uart_tx_fifo: RTL

- Byte FIFO between the core's memory-mapped UART TX register and the `uart_tx` serializer; sits directly upstream of `uart_tx`.
- Accepts single-cycle byte pushes from the memory-mapped I/O write path.
- Buffers up to DEPTH bytes and feeds `uart_tx` one byte at a time using its start/ready handshake.
- Exposes fill status so software can poll before writing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo_if.sv | 31 +++
 rtl/uart_tx_fifo_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX byte FIFO: data width, TX handshake states, line-ending bytes.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

    localparam logic [UART_DATA_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [UART_DATA_W-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the memory-mapped write path, fill status and uart_tx handshake around the TX FIFO.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = UART_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) ();

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              clr;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output wr_en, wr_data, clr, tx_ready,
        input  full, empty, count, overflow, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, clr, tx_ready,
        output full, empty, count, overflow, tx_start, tx_data
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous byte FIFO: storage, wrapping pointers, separate occupancy count, sticky overflow, flush.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = UART_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_push;
    logic              w_pop;

    // Full is judged on pre-edge state, so a same-cycle pop never makes room for a push.
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_rd_data  = r_mem[r_rd_ptr];

    assign w_push = i_wr_en && !o_full && !i_clr;
    assign w_pop  = i_rd_en && !o_empty && !i_clr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr_en && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx through its start/ready handshake.
// Define UART_TX_FIFO_CRLF_EN to expand each LF into CR followed by LF on the wire.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DATA_W = UART_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic              r_guard;
    logic              w_guard_nxt;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_tx_data_nxt;
    logic [DATA_W-1:0] w_head;
    logic              w_issue;
    logic              w_pop;
    logic              w_empty;
`ifdef UART_TX_FIFO_CRLF_EN
    logic              r_cr_sent;
    logic              w_cr_sent_nxt;
`endif

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (bus.clr),
        .i_wr_en    (bus.wr_en),
        .i_wr_data  (bus.wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_full     (bus.full),
        .o_empty    (w_empty),
        .o_count    (bus.count),
        .o_overflow (bus.overflow)
    );

    assign bus.empty    = w_empty;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_guard_nxt   = r_guard;
        w_tx_data_nxt = r_tx_data;
        w_issue       = 1'b0;
        w_pop         = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        w_cr_sent_nxt = r_cr_sent;
`endif
        case (r_state)
            IDLE: begin
                w_guard_nxt = 1'b0;
                if (!w_empty && bus.tx_ready && !bus.clr) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT_BUSY;
`ifdef UART_TX_FIFO_CRLF_EN
                    // CR goes out first and leaves the LF at the head for the next issue.
                    if (w_head == ASCII_LF && !r_cr_sent) begin
                        w_tx_data_nxt = ASCII_CR;
                        w_cr_sent_nxt = 1'b1;
                    end else begin
                        w_tx_data_nxt = w_head;
                        w_pop         = 1'b1;
                        w_cr_sent_nxt = 1'b0;
                    end
`else
                    w_tx_data_nxt = w_head;
                    w_pop         = 1'b1;
`endif
                end
            end
            WAIT_BUSY: begin
                // Don't hang if uart_tx never visibly drops ready.
                if (!bus.tx_ready || r_guard) begin
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_guard_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state    <= IDLE;
            r_guard    <= 1'b0;
            r_tx_start <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
            r_cr_sent  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_guard    <= w_guard_nxt;
            r_tx_start <= w_issue;
`ifdef UART_TX_FIFO_CRLF_EN
            r_cr_sent  <= w_cr_sent_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data <= '0;
        end else begin
            r_tx_data <= w_tx_data_nxt;
        end
    end

endmodule
